// File: rtl/pwm_mod_pkg.sv
// Shared types and sample-to-duty helpers for the multi-channel PWM modulator.
package pwm_mod_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } state_e;

    // Counter width that stays at least one bit, so a prescaler of 1 remains legal.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic logic [31:0] to_offset(input logic [31:0] s, input int bits,
                                              input bit signed_in);
        return signed_in ? (s ^ (32'd1 << (bits - 1))) : s;
    endfunction

    function automatic logic [31:0] sat_duty(input logic [31:0] value, input logic [31:0] max);
        return (value > max) ? max : value;
    endfunction

endpackage

// File: rtl/pwm_modulator_nch_channel.sv
// One PWM channel: duty register with underrun policy, step compare and output register.
module pwm_channel
    import pwm_mod_pkg::*;
#(
    parameter int SAMPLE_BITS      = 8,
    parameter int STEP_W           = 8,
    parameter int STEPS_PER_SAMPLE = 255,
    parameter int SIGNED_IN        = 0,
    parameter int UNDERRUN_MODE    = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load_i,
    input  logic                   underrun_i,
    input  logic                   run_i,
    input  logic [SAMPLE_BITS-1:0] sample_i,
    input  logic [STEP_W-1:0]      step_i,
    output logic                   pwm_o
);

    localparam logic [31:0] MIDSCALE = 32'd1 << (SAMPLE_BITS - 1);
    localparam logic [SAMPLE_BITS-1:0] MID_DUTY =
        SAMPLE_BITS'(sat_duty(MIDSCALE, 32'(STEPS_PER_SAMPLE)));

    logic [SAMPLE_BITS-1:0] duty_q, duty_d, sample_duty;
    logic                   pwm_q;

    always_comb begin
        // NOTE: every always_comb target gets a default first, otherwise a latch is inferred.
        duty_d      = duty_q;
        sample_duty = SAMPLE_BITS'(sat_duty(to_offset(32'(sample_i), SAMPLE_BITS, SIGNED_IN != 0),
                                            32'(STEPS_PER_SAMPLE)));
        if (load_i) begin
            duty_d = sample_duty;
        end else if (underrun_i && (UNDERRUN_MODE != 0)) begin
            duty_d = MID_DUTY;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            duty_q <= '0;
            pwm_q  <= 1'b0;
        end else begin
            duty_q <= duty_d;
            pwm_q  <= run_i && (32'(step_i) < 32'(duty_q));
        end
    end

    assign pwm_o = pwm_q;

endmodule

// File: rtl/pwm_modulator_nch.sv
// Multi-channel PWM modulator: FSM, prescaler/step counters and FWFT FIFO handshake.
module pwm_modulator_nch
    import pwm_mod_pkg::*;
#(
    parameter int NUM_CH           = 2,
    parameter int SAMPLE_BITS      = 8,
    parameter int CLKS_PER_STEP    = 10,
    parameter int STEPS_PER_SAMPLE = 255,
    parameter int SIGNED_IN        = 0,
    parameter int UNDERRUN_MODE    = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic [NUM_CH*SAMPLE_BITS-1:0] sample,
    input  logic                          empty,
    output logic                          read,
    output logic [NUM_CH-1:0]             pwm,
    output logic                          symb_clk,
    output logic                          underrun
);

    localparam int STEP_W = cnt_width(STEPS_PER_SAMPLE);
    localparam int PRE_W  = cnt_width(CLKS_PER_STEP);
    localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(CLKS_PER_STEP - 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEPS_PER_SAMPLE - 1);

    state_e            state_q;
    logic [PRE_W-1:0]  pre_q;
    logic [STEP_W-1:0] step_q;
    logic              symb_q;

    logic step_tick, period_end, prime_take, run_take, run_under, load;

    assign step_tick  = (pre_q == PRE_LAST);
    assign period_end = step_tick && (step_q == STEP_LAST);
    assign prime_take = (state_q == PRIME) && enable && !empty;
    assign run_take   = (state_q == RUN) && enable && period_end && !empty;
    assign run_under  = (state_q == RUN) && enable && period_end && empty;
    assign load       = prime_take || run_take;

    // The pop must coincide with the FWFT head word, so read is decoded from the current state.
    assign read     = !rst && load;
    assign underrun = !rst && run_under;
    assign symb_clk = symb_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pre_q   <= '0;
            step_q  <= '0;
            symb_q  <= 1'b0;
        end else begin
            symb_q <= (state_q == RUN) && (pre_q == '0) && (step_q == '0);
            case (state_q)
                IDLE: begin
                    pre_q  <= '0;
                    step_q <= '0;
                    if (enable) state_q <= PRIME;
                end
                PRIME: begin
                    pre_q  <= '0;
                    step_q <= '0;
                    if (!enable)     state_q <= IDLE;
                    else if (!empty) state_q <= RUN;
                end
                RUN: begin
                    if (!enable) begin
                        state_q <= IDLE;
                        pre_q   <= '0;
                        step_q  <= '0;
                    end else begin
                        pre_q <= step_tick ? '0 : pre_q + PRE_W'(1);
                        if (step_tick) step_q <= period_end ? '0 : step_q + STEP_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        pwm_channel #(
            .SAMPLE_BITS      (SAMPLE_BITS),
            .STEP_W           (STEP_W),
            .STEPS_PER_SAMPLE (STEPS_PER_SAMPLE),
            .SIGNED_IN        (SIGNED_IN),
            .UNDERRUN_MODE    (UNDERRUN_MODE)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .load_i     (load),
            .underrun_i (run_under),
            .run_i      (state_q == RUN),
            .sample_i   (sample[k*SAMPLE_BITS +: SAMPLE_BITS]),
            .step_i     (step_q),
            .pwm_o      (pwm[k])
        );
    end

endmodule

// File: tb/tb_pwm_modulator_nch.sv
// Bench for pwm_modulator_nch: hand-derived per-segment counts plus a period-time reference model.
module tb_pwm_modulator_nch;

    localparam int CPS    = 2;
    localparam int SPS    = 15;
    localparam int PERIOD = CPS * SPS;
    localparam int M_IDLE = 0, M_PRIME = 1, M_RUN = 2;

    logic       clk = 1'b0;
    logic       rst, enable, empty;
    logic [7:0] sample;
    logic       read_a, und_a, symb_a, read_b, und_b, symb_b;
    logic [1:0] pwm_a, pwm_b;

    always #5 clk = ~clk;

    // a: unsigned input, hold on underrun; b: signed input, midscale on underrun
    pwm_modulator_nch #(
        .NUM_CH(2), .SAMPLE_BITS(4), .CLKS_PER_STEP(CPS), .STEPS_PER_SAMPLE(SPS),
        .SIGNED_IN(0), .UNDERRUN_MODE(0)
    ) dut_a (
        .clk(clk), .rst(rst), .enable(enable), .sample(sample), .empty(empty),
        .read(read_a), .pwm(pwm_a), .symb_clk(symb_a), .underrun(und_a)
    );

    pwm_modulator_nch #(
        .NUM_CH(2), .SAMPLE_BITS(4), .CLKS_PER_STEP(CPS), .STEPS_PER_SAMPLE(SPS),
        .SIGNED_IN(1), .UNDERRUN_MODE(1)
    ) dut_b (
        .clk(clk), .rst(rst), .enable(enable), .sample(sample), .empty(empty),
        .read(read_b), .pwm(pwm_b), .symb_clk(symb_b), .underrun(und_b)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // reference model: state, clocks elapsed in the current period, duties per design/channel
    int         m_state;
    int         m_t;
    int         m_duty [2][2];
    logic [1:0] m_pwm  [2];
    logic       m_symb;

    int rc_read, rc_und, rc_h0, rc_h1, rc_symb;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic int conv(input int raw, input bit sgn);
        int off;
        off = sgn ? (raw ^ 8) : raw;
        return (off > SPS) ? SPS : off;
    endfunction

    task automatic model_reset();
        m_state = M_IDLE;
        m_t     = 0;
        m_symb  = 1'b0;
        for (int d = 0; d < 2; d++) begin
            m_pwm[d] = 2'b00;
            for (int k = 0; k < 2; k++) m_duty[d][k] = 0;
        end
    endtask

    task automatic model_load(input logic [7:0] smp);
        for (int d = 0; d < 2; d++)
            for (int k = 0; k < 2; k++)
                m_duty[d][k] = conv((int'(smp) >> (4 * k)) & 15, d == 1);
    endtask

    task automatic tick(input logic r, input logic en, input logic em, input logic [7:0] smp);
        logic pend, e_read, e_und;
        @(negedge clk);
        rst = r; enable = en; empty = em; sample = smp;
        #1;
        pend   = (m_state == M_RUN) && (m_t == PERIOD - 1);
        e_read = !r && en && !em && ((m_state == M_PRIME) || pend);
        e_und  = !r && en && em && pend;
        check("read_a", 32'(read_a), 32'(e_read));
        check("read_b", 32'(read_b), 32'(e_read));
        check("underrun_a", 32'(und_a), 32'(e_und));
        check("underrun_b", 32'(und_b), 32'(e_und));
        check("pwm_a", 32'(pwm_a), 32'(m_pwm[0]));
        check("pwm_b", 32'(pwm_b), 32'(m_pwm[1]));
        check("symb_a", 32'(symb_a), 32'(m_symb));
        check("symb_b", 32'(symb_b), 32'(m_symb));
        rc_read += int'(read_a);
        rc_und  += int'(und_a);
        rc_h0   += int'(pwm_a[0]);
        rc_h1   += int'(pwm_a[1]);
        rc_symb += int'(symb_a);
        @(posedge clk);
        cyc++;
        if (r) begin
            model_reset();
        end else begin
            for (int d = 0; d < 2; d++)
                for (int k = 0; k < 2; k++)
                    m_pwm[d][k] = (m_state == M_RUN) && ((m_t / CPS) < m_duty[d][k]);
            m_symb = (m_state == M_RUN) && (m_t == 0);
            case (m_state)
                M_IDLE:  if (en) m_state = M_PRIME;
                M_PRIME: begin
                    if (!en) m_state = M_IDLE;
                    else if (!em) begin
                        model_load(smp);
                        m_t     = 0;
                        m_state = M_RUN;
                    end
                end
                default: begin
                    if (!en) begin
                        m_state = M_IDLE;
                        m_t     = 0;
                    end else if (pend) begin
                        m_t = 0;
                        if (!em) model_load(smp);
                        else for (int k = 0; k < 2; k++) m_duty[1][k] = conv(8, 1'b0);
                    end else begin
                        m_t++;
                    end
                end
            endcase
        end
    endtask

    typedef struct {
        logic       r, en, em;
        logic [7:0] smp;
        int         n;
        int         reads, unds, h0, h1, symbs;
    } row_t;

    row_t rows [20];

    initial begin
        rows[0]  = '{1'b1, 1'b0, 1'b1, 8'h00,  2, 0, 0,  0,  0, 0}; // reset
        rows[1]  = '{1'b0, 1'b1, 1'b0, 8'h39, 62, 3, 0, 36, 12, 2}; // prime and run
        rows[2]  = '{1'b0, 1'b1, 1'b0, 8'h0F, 30, 1, 0, 18,  6, 1};
        rows[3]  = '{1'b0, 1'b1, 1'b0, 8'h35, 30, 1, 0, 29,  0, 1}; // duty 15 / duty 0
        rows[4]  = '{1'b0, 1'b1, 1'b1, 8'h35, 30, 0, 1, 11,  6, 1}; // underrun
        rows[5]  = '{1'b0, 1'b1, 1'b0, 8'h39, 30, 1, 0, 10,  6, 1}; // held duty repeats
        rows[6]  = '{1'b0, 1'b1, 1'b0, 8'h39, 29, 0, 0, 18,  6, 1};
        rows[7]  = '{1'b0, 1'b0, 1'b0, 8'h39,  1, 0, 0,  0,  0, 0}; // enable drop at period end
        rows[8]  = '{1'b0, 1'b0, 1'b0, 8'h39,  3, 0, 0,  0,  0, 0};
        rows[9]  = '{1'b0, 1'b1, 1'b0, 8'h39,  3, 1, 0,  0,  0, 0}; // re-enable
        rows[10] = '{1'b0, 1'b1, 1'b0, 8'h39, 13, 0, 0, 13,  6, 1};
        rows[11] = '{1'b1, 1'b1, 1'b0, 8'h39,  2, 0, 0,  1,  0, 0}; // reset at step 7
        rows[12] = '{1'b0, 1'b1, 1'b0, 8'h39, 62, 3, 0, 36, 12, 2}; // recovery
        rows[13] = '{1'b1, 1'b1, 1'b0, 8'h39,  1, 0, 0,  0,  0, 0};
        rows[14] = '{1'b0, 1'b1, 1'b1, 8'h39, 50, 0, 0,  0,  0, 0}; // start-up empty
        rows[15] = '{1'b0, 1'b1, 1'b0, 8'h39,  2, 1, 0,  0,  0, 0};
        rows[16] = '{1'b0, 1'b0, 1'b1, 8'h39,  1, 0, 0,  1,  1, 1};
        rows[17] = '{1'b0, 1'b1, 1'b1, 8'h39,  1, 0, 0,  1,  1, 0};
        rows[18] = '{1'b1, 1'b1, 1'b0, 8'h39,  1, 0, 0,  0,  0, 0}; // reset while priming
        rows[19] = '{1'b0, 1'b0, 1'b0, 8'h39,  2, 0, 0,  0,  0, 0};

        rst = 1'b1; enable = 1'b0; empty = 1'b1; sample = 8'h00;
        repeat (2) @(posedge clk);
        model_reset();

        for (int i = 0; i < 20; i++) begin
            rc_read = 0; rc_und = 0; rc_h0 = 0; rc_h1 = 0; rc_symb = 0;
            for (int c = 0; c < rows[i].n; c++)
                tick(rows[i].r, rows[i].en, rows[i].em, rows[i].smp);
            check($sformatf("row%0d reads", i),    32'(rc_read), 32'(rows[i].reads));
            check($sformatf("row%0d underruns", i), 32'(rc_und), 32'(rows[i].unds));
            check($sformatf("row%0d ch0 high", i),  32'(rc_h0),   32'(rows[i].h0));
            check($sformatf("row%0d ch1 high", i),  32'(rc_h1),   32'(rows[i].h1));
            check($sformatf("row%0d symb", i),      32'(rc_symb), 32'(rows[i].symbs));
        end

        for (int c = 0; c < 3000; c++) begin
            logic       r, en, em;
            logic [7:0] smp;
            r   = ($urandom_range(0, 599) == 0);
            en  = ($urandom_range(0, 99) < 97);
            em  = ($urandom_range(0, 3) == 0);
            smp = 8'($urandom);
            tick(r, en, em, smp);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
